// File: rtl/ac_control_sequencer.sv
// ac_control_sequencer: fetch/decode/execute sequencer driving the accumulator ALU datapath
module ac_control_sequencer #(
    parameter logic [11:0] RESET_PC = 12'h000,
    parameter int          AW       = 12
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [15:0]   mem_rdata,
    output logic [AW-1:0] mem_addr,
    output logic          dr_ld,
    output logic          and_op,
    output logic          add_op,
    output logic          lda_op,
    output logic          cma_op,
    output logic          cir_op,
    output logic          cil_op,
    output logic          ac_ld,
    output logic          ac_clr,
    output logic          ac_inr,
    output logic          e_ld,
    output logic          e_clr,
    output logic          e_cmp,
    output logic          running,
    output logic [AW-1:0] pc,
    output logic [2:0]    sc
);
    logic [AW-1:0] ar;
    logic [15:0]   ir;
    logic          ibit;
    logic          mem_ref, reg_ref, t3r, t4, t5, hlt;
    logic [6:0]    p;

    assign mem_addr = ar;
    assign p        = ir[11:5];
    assign mem_ref  = ir[14:12] <= 3'd2;
    assign reg_ref  = ir[15:12] == 4'h7;
    assign t3r      = running & (sc == 3'd3) & reg_ref;
    assign t4       = running & (sc == 3'd4) & mem_ref;
    assign t5       = running & (sc == 3'd5) & mem_ref;
    assign hlt      = reg_ref & ir[0] & ~|p;
    assign dr_ld    = t4;
    assign and_op   = t5 & (ir[14:12] == 3'd0);
    assign add_op   = t5 & (ir[14:12] == 3'd1);
    assign lda_op   = t5 & (ir[14:12] == 3'd2);
    assign ac_clr   = t3r & p[6];
    assign e_clr    = t3r & p[5] & ~p[6];
    assign cma_op   = t3r & p[4] & ~|p[6:5];
    assign e_cmp    = t3r & p[3] & ~|p[6:4];
    assign cir_op   = t3r & p[2] & ~|p[6:3];
    assign cil_op   = t3r & p[1] & ~|p[6:2];
    assign ac_inr   = t3r & p[0] & ~|p[6:1];
    assign ac_ld    = and_op | add_op | lda_op | cma_op | cir_op | cil_op;
    assign e_ld     = add_op | cir_op | cil_op;

    // timing-step sequencer: start/halt control plus PC/AR/IR/I updates per step
    always_ff @(posedge clk) begin
        if (rst) begin
            pc      <= RESET_PC;
            ar      <= '0;
            ir      <= '0;
            ibit    <= 1'b0;
            sc      <= 3'd0;
            running <= 1'b0;
        end else if (!running) begin
            if (start) begin
                running <= 1'b1;
                sc      <= 3'd0;
            end
        end else begin
            case (sc)
                3'd0: begin
                    ar <= pc;
                    sc <= 3'd1;
                end
                3'd1: begin
                    ir <= mem_rdata;
                    pc <= pc + 1'b1;
                    sc <= 3'd2;
                end
                3'd2: begin
                    ar   <= ir[11:0];
                    ibit <= ir[15];
                    sc   <= 3'd3;
                end
                3'd3: begin
                    if (mem_ref && ibit) ar <= mem_rdata[11:0];
                    if (hlt) running <= 1'b0;
                    sc <= mem_ref ? 3'd4 : 3'd0;
                end
                3'd4: sc <= 3'd5;
                default: sc <= 3'd0;
            endcase
        end
    end
endmodule

// File: tb/tb_ac_control_sequencer.sv
// tb_ac_control_sequencer: scoreboard bench comparing per-cycle sequencer behaviour to an ISA model
module tb_ac_control_sequencer;
    localparam logic [11:0] RP = 12'h0C0;
    localparam logic [12:0] DR = 13'h1000, ANDS = 13'h0800, ADDS = 13'h0400, LDAS = 13'h0200,
                            CMAS = 13'h0100, CIRS = 13'h0080, CILS = 13'h0040, ACLD = 13'h0020,
                            ACLR = 13'h0010, AINR = 13'h0008, ELD = 13'h0004, ECLR = 13'h0002,
                            ECMP = 13'h0001;

    typedef struct {
        logic [2:0]  sc;
        logic [11:0] pc;
        logic [11:0] addr;
        logic [12:0] st;
    } exp_t;

    logic clk = 1'b0, rst = 1'b1, start = 1'b0;
    logic [15:0] mem_rdata;
    logic [11:0] mem_addr, pc;
    logic [2:0]  sc;
    logic dr_ld, and_op, add_op, lda_op, cma_op, cir_op, cil_op;
    logic ac_ld, ac_clr, ac_inr, e_ld, e_clr, e_cmp, running;
    logic [12:0] strb;
    logic [15:0] mem [4096];
    logic [11:0] m_pc, m_ar;
    exp_t q[$];
    int n_cmp = 0, n_bad = 0;

    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr];
    assign strb = {dr_ld, and_op, add_op, lda_op, cma_op, cir_op, cil_op,
                   ac_ld, ac_clr, ac_inr, e_ld, e_clr, e_cmp};

    ac_control_sequencer #(.RESET_PC(RP)) dut (
        .clk(clk), .rst(rst), .start(start), .mem_rdata(mem_rdata), .mem_addr(mem_addr),
        .dr_ld(dr_ld), .and_op(and_op), .add_op(add_op), .lda_op(lda_op), .cma_op(cma_op),
        .cir_op(cir_op), .cil_op(cil_op), .ac_ld(ac_ld), .ac_clr(ac_clr), .ac_inr(ac_inr),
        .e_ld(e_ld), .e_clr(e_clr), .e_cmp(e_cmp), .running(running), .pc(pc), .sc(sc)
    );

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic push(input logic [2:0] s, input logic [12:0] st);
        exp_t e;
        e.sc = s; e.pc = m_pc; e.addr = m_ar; e.st = st;
        q.push_back(e);
    endtask

    task automatic model_instr(output bit h);
        logic [15:0] ir;
        logic [12:0] st;
        h = 1'b0;
        push(3'd0, '0);
        m_ar = m_pc;
        push(3'd1, '0);
        ir = mem[m_ar];
        m_pc = m_pc + 12'd1;
        push(3'd2, '0);
        m_ar = ir[11:0];
        if (ir[14:12] == 3'd0 || ir[14:12] == 3'd1 || ir[14:12] == 3'd2) begin
            push(3'd3, '0);
            if (ir[15]) m_ar = mem[m_ar][11:0];
            push(3'd4, DR);
            st = (ir[14:12] == 3'd0) ? (ANDS | ACLD) :
                 (ir[14:12] == 3'd1) ? (ADDS | ACLD | ELD) : (LDAS | ACLD);
            push(3'd5, st);
        end else if (ir[15:12] == 4'h7) begin
            st = '0;
            if (ir[11]) st = ACLR;
            else if (ir[10]) st = ECLR;
            else if (ir[9]) st = CMAS | ACLD;
            else if (ir[8]) st = ECMP;
            else if (ir[7]) st = CIRS | ACLD | ELD;
            else if (ir[6]) st = CILS | ACLD | ELD;
            else if (ir[5]) st = AINR;
            else h = ir[0];
            push(3'd3, st);
        end else begin
            push(3'd3, '0);
        end
    endtask

    task automatic cmp_next();
        exp_t e;
        e = q.pop_front();
        chk("sc", {13'd0, sc}, {13'd0, e.sc});
        chk("pc", {4'd0, pc}, {4'd0, e.pc});
        chk("mem_addr", {4'd0, mem_addr}, {4'd0, e.addr});
        chk("strobes", {3'd0, strb}, {3'd0, e.st});
        chk("running", {15'd0, running}, 16'd1);
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n && q.size() > 0; i++) begin
            cmp_next();
            start = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        start = 1'b0;
    endtask

    task automatic go();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic run_prog();
        bit h;
        do begin
            model_instr(h);
            drain(q.size());
        end while (!h);
        chk("halt_running", {15'd0, running}, 16'd0);
        chk("halt_pc", {4'd0, pc}, {4'd0, m_pc});
        chk("halt_sc", {13'd0, sc}, 16'd0);
        chk("halt_strobes", {3'd0, strb}, 16'd0);
        @(negedge clk);
        chk("idle_running", {15'd0, running}, 16'd0);
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_running"}, {15'd0, running}, 16'd0);
        chk({tag, "_sc"}, {13'd0, sc}, 16'd0);
        chk({tag, "_pc"}, {4'd0, pc}, {4'd0, RP});
        chk({tag, "_addr"}, {4'd0, mem_addr}, 16'd0);
        chk({tag, "_strobes"}, {3'd0, strb}, 16'd0);
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = 16'h0000;
        mem[12'h0C0] = 16'h2005; mem[12'h0C1] = 16'h7001; mem[12'h005] = 16'h0003;
        mem[12'h0C2] = 16'hA0F0; mem[12'h0F0] = 16'h0100; mem[12'h100] = 16'h1234;
        mem[12'h0C3] = 16'h7280; mem[12'h0C4] = 16'h7040; mem[12'h0C5] = 16'h7020;
        mem[12'h0C6] = 16'h7001;
        mem[12'h0C7] = 16'h3005; mem[12'h0C8] = 16'hF800; mem[12'h0C9] = 16'h0800;
        mem[12'h0CA] = 16'h7800; mem[12'h0CB] = 16'h7400; mem[12'h0CC] = 16'h7100;
        mem[12'h0CD] = 16'h701E; mem[12'h0CE] = 16'h7000; mem[12'h0CF] = 16'h8FFF;
        mem[12'hFFF] = 16'h0ABC; mem[12'h0D0] = 16'h7001;
        mem[12'h0D1] = 16'h1005;
        m_pc = RP;
        m_ar = 12'h000;
        repeat (2) @(negedge clk);
        check_reset_state("reset");
        rst = 1'b0;
        @(negedge clk);
        check_reset_state("idle");
        go();
        run_prog();
        go();
        run_prog();
        go();
        run_prog();
        go();
        begin
            bit h;
            model_instr(h);
        end
        drain(4);
        cmp_next();
        rst = 1'b1;
        start = 1'b1;
        @(negedge clk);
        check_reset_state("midrst");
        q.delete();
        rst = 1'b0;
        start = 1'b0;
        m_pc = RP;
        m_ar = 12'h000;
        @(negedge clk);
        go();
        run_prog();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
